mem_stage: RTL and testbench

//  Memory stage of the 5-stage RV32I pipeline, directly downstream of EX; consumes EX/MEM register outputs.

---
 rtl/mem_stage.sv | 173 +++++++++++++++++
 tb/tb_mem_stage.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// RV32I memory stage: data-bus handshake, store lane alignment, load extension,
// write-back select and the MEM/WB pipeline register.
module mem_stage #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] i_ResultM,
    input  logic [31:0] i_DataStoreM,
    input  logic [2:0]  i_Func3M,
    input  logic [4:0]  i_RdM,
    input  logic        i_RegSrcM,
    input  logic        i_MemSrcM,
    input  logic        i_LoadM,
    input  logic [1:0]  i_ResultSrcM,
    input  logic [31:0] i_PcM,
    output logic        o_dmem_req,
    output logic        o_dmem_we,
    output logic [31:0] o_dmem_addr,
    output logic [31:0] o_dmem_wdata,
    output logic [3:0]  o_dmem_wstrb,
    input  logic        i_dmem_gnt,
    input  logic        i_dmem_rvalid,
    input  logic [31:0] i_dmem_rdata,
    output logic        o_stall,
    output logic        o_misaligned,
    output logic        o_bus_err,
    output logic [31:0] o_ResultW,
    output logic [4:0]  o_RdW,
    output logic        o_RegSrcW
);
    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] WAIT_GNT = 2'd1;
    localparam logic [1:0] WAIT_RSP = 2'd2;
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    logic [1:0]    state, state_nxt;
    logic [CW-1:0] to_cnt;
    logic          replay_q;
    logic [2:0]    func3_q;
    logic [1:0]    off_q;
    logic [4:0]    rd_q;
    logic          regsrc_q;

    logic        mem_op, is_half, is_word, misal, idle_live, issue;
    logic        gnt_done, store_done, rsp_done, timeout_hit, wb_alu;
    logic [31:0] wb_sel, load_sh, load_ext;

    assign mem_op    = i_LoadM | i_MemSrcM;
    assign is_half   = (i_Func3M[1:0] == 2'b01);
    assign is_word   = (i_Func3M[1:0] == 2'b10);
    assign misal     = (is_half & i_ResultM[0]) | (is_word & (i_ResultM[1:0] != 2'b00));
    // The completing cycle is stalled, so EX/MEM still holds the finished op one cycle later.
    assign idle_live = (state == IDLE) & ~replay_q;
    assign issue     = idle_live & mem_op & ~misal;

    assign gnt_done    = (issue | (state == WAIT_GNT)) & i_dmem_gnt;
    assign store_done  = gnt_done & i_MemSrcM;
    assign rsp_done    = (state == WAIT_RSP) & i_dmem_rvalid;
    assign timeout_hit = (TIMEOUT != 0) && (state == WAIT_RSP) && !i_dmem_rvalid
                         && (to_cnt == CW'(TIMEOUT - 1));
    assign wb_alu      = (idle_live & ~mem_op) | store_done;

    assign o_dmem_req   = ~rst & (issue | (state == WAIT_GNT));
    assign o_dmem_we    = i_MemSrcM;
    assign o_dmem_addr  = {i_ResultM[31:2], 2'b00};
    assign o_stall      = ~rst & ((issue & ~(i_MemSrcM & i_dmem_gnt))
                                  | (state == WAIT_GNT) | (state == WAIT_RSP));
    assign o_misaligned = idle_live & mem_op & misal;
    assign o_bus_err    = timeout_hit;

    always_comb begin
        // NOTE: defaults first so every path assigns every output -- no latch is inferred.
        o_dmem_wdata = i_DataStoreM;
        o_dmem_wstrb = 4'b1111;
        case (i_Func3M[1:0])
            2'b00: begin
                o_dmem_wdata = {4{i_DataStoreM[7:0]}};
                o_dmem_wstrb = 4'b0001 << i_ResultM[1:0];
            end
            2'b01: begin
                o_dmem_wdata = {2{i_DataStoreM[15:0]}};
                o_dmem_wstrb = 4'b0011 << {i_ResultM[1], 1'b0};
            end
            default: ;
        endcase
        if (!i_MemSrcM) o_dmem_wstrb = 4'b0000;
    end

    always_comb begin
        load_sh  = i_dmem_rdata >> {off_q, 3'b000};
        load_ext = i_dmem_rdata;
        case (func3_q)
            3'b000:  load_ext = {{24{load_sh[7]}}, load_sh[7:0]};
            3'b001:  load_ext = {{16{load_sh[15]}}, load_sh[15:0]};
            3'b100:  load_ext = {24'b0, load_sh[7:0]};
            3'b101:  load_ext = {16'b0, load_sh[15:0]};
            default: load_ext = i_dmem_rdata;
        endcase
    end

    always_comb begin
        wb_sel = i_ResultM;
        if (i_ResultSrcM == 2'b10) wb_sel = i_PcM + 32'd4;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (issue) begin
                    if (!i_dmem_gnt)    state_nxt = WAIT_GNT;
                    else if (!i_MemSrcM) state_nxt = WAIT_RSP;
                end
            end
            WAIT_GNT: begin
                if (i_dmem_gnt) state_nxt = i_MemSrcM ? IDLE : WAIT_RSP;
            end
            WAIT_RSP: begin
                if (rsp_done || timeout_hit) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            to_cnt   <= '0;
            replay_q <= 1'b0;
        end else begin
            state    <= state_nxt;
            replay_q <= (state != IDLE) && (state_nxt == IDLE);
            if (state != WAIT_RSP) to_cnt <= '0;
            else                   to_cnt <= to_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            func3_q  <= 3'b000;
            off_q    <= 2'b00;
            rd_q     <= 5'd0;
            regsrc_q <= 1'b0;
        end else if (issue) begin
            func3_q  <= i_Func3M;
            off_q    <= i_ResultM[1:0];
            rd_q     <= i_RdM;
            regsrc_q <= i_RegSrcM;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_ResultW <= 32'd0;
            o_RdW     <= 5'd0;
            o_RegSrcW <= 1'b0;
        end else if (rsp_done) begin
            o_ResultW <= load_ext;
            o_RdW     <= rd_q;
            o_RegSrcW <= regsrc_q;
        end else if (wb_alu) begin
            o_ResultW <= wb_sel;
            o_RdW     <= i_RdM;
            o_RegSrcW <= i_RegSrcM;
        end else begin
            o_ResultW <= 32'd0;
            o_RdW     <= 5'd0;
            o_RegSrcW <= 1'b0;
        end
    end
endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: directed ALU/store/load/misaligned/timeout/reset vectors;
// write-backs are predicted into a queue and checked by a separate monitor.
`timescale 1ns/1ps
module tb_mem_stage;
    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] i_ResultM, i_DataStoreM, i_PcM, i_dmem_rdata;
    logic [2:0]  i_Func3M;
    logic [4:0]  i_RdM;
    logic        i_RegSrcM, i_MemSrcM, i_LoadM, i_dmem_gnt, i_dmem_rvalid;
    logic [1:0]  i_ResultSrcM;
    logic        o_dmem_req, o_dmem_we, o_stall, o_misaligned, o_bus_err, o_RegSrcW;
    logic [31:0] o_dmem_addr, o_dmem_wdata, o_ResultW;
    logic [3:0]  o_dmem_wstrb;
    logic [4:0]  o_RdW;

    typedef struct packed {
        logic [31:0] res;
        logic [4:0]  rd;
    } wb_t;

    wb_t sb[$];
    int  n_checks = 0;
    int  n_errors = 0;

    mem_stage #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .i_ResultM(i_ResultM), .i_DataStoreM(i_DataStoreM), .i_Func3M(i_Func3M),
        .i_RdM(i_RdM), .i_RegSrcM(i_RegSrcM), .i_MemSrcM(i_MemSrcM), .i_LoadM(i_LoadM),
        .i_ResultSrcM(i_ResultSrcM), .i_PcM(i_PcM),
        .o_dmem_req(o_dmem_req), .o_dmem_we(o_dmem_we), .o_dmem_addr(o_dmem_addr),
        .o_dmem_wdata(o_dmem_wdata), .o_dmem_wstrb(o_dmem_wstrb),
        .i_dmem_gnt(i_dmem_gnt), .i_dmem_rvalid(i_dmem_rvalid), .i_dmem_rdata(i_dmem_rdata),
        .o_stall(o_stall), .o_misaligned(o_misaligned), .o_bus_err(o_bus_err),
        .o_ResultW(o_ResultW), .o_RdW(o_RdW), .o_RegSrcW(o_RegSrcW)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic monitor();
        wb_t e;
        forever begin
            @(negedge clk);
            if (rst === 1'b0 && o_RegSrcW === 1'b1) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL wb_unexpected: write rd=%0d data=0x%08h, expected no write",
                             o_RdW, o_ResultW);
                end else begin
                    e = sb.pop_front();
                    check("wb_data", o_ResultW, e.res);
                    check("wb_rd", {27'b0, o_RdW}, {27'b0, e.rd});
                end
            end
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [31:0] res, input logic [31:0] dat, input logic [2:0] f3,
                          input logic [4:0] rd, input logic regsrc, input logic st, input logic ld,
                          input logic [1:0] rsrc, input logic [31:0] pc);
        i_ResultM = res; i_DataStoreM = dat; i_Func3M = f3; i_RdM = rd; i_RegSrcM = regsrc;
        i_MemSrcM = st; i_LoadM = ld; i_ResultSrcM = rsrc; i_PcM = pc;
    endtask

    task automatic set_bubble();
        set_op(32'h0, 32'h0, 3'b000, 5'd0, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0);
    endtask

    task automatic push_exp(input logic [31:0] res, input logic [4:0] rd);
        wb_t e;
        e.res = res;
        e.rd  = rd;
        sb.push_back(e);
    endtask

    task automatic run_alu(input logic [31:0] res, input logic [4:0] rd, input logic regsrc,
                           input logic [1:0] rsrc, input logic [31:0] pc, input logic [31:0] exp_val);
        if (regsrc) push_exp(exp_val, rd);
        set_op(res, 32'h0, 3'b000, rd, regsrc, 1'b0, 1'b0, rsrc, pc);
        @(negedge clk);
        check("alu_req", {31'b0, o_dmem_req}, 32'd0);
        check("alu_stall", {31'b0, o_stall}, 32'd0);
        next_cycle();
    endtask

    task automatic run_store(input string name, input logic [31:0] addr, input logic [31:0] dat,
                             input logic [2:0] f3, input int gnt_dly, input logic [31:0] exp_wdata,
                             input logic [3:0] exp_wstrb, input int exp_req, input int exp_stall);
        int n_req   = 0;
        int n_stall = 0;
        set_op(addr, dat, f3, 5'd0, 1'b0, 1'b1, 1'b0, 2'b00, 32'h0);
        for (int c = 0; c <= gnt_dly; c++) begin
            i_dmem_gnt = (c == gnt_dly);
            @(negedge clk);
            if (o_dmem_req) n_req++;
            if (o_stall) n_stall++;
            if (c == gnt_dly) begin
                check({name, "_we"}, {31'b0, o_dmem_we}, 32'd1);
                check({name, "_addr"}, o_dmem_addr, {addr[31:2], 2'b00});
                check({name, "_wdata"}, o_dmem_wdata, exp_wdata);
                check({name, "_wstrb"}, {28'b0, o_dmem_wstrb}, {28'b0, exp_wstrb});
            end
            next_cycle();
        end
        set_bubble();
        i_dmem_gnt = 1'b0;
        @(negedge clk);
        check({name, "_req_after"}, {31'b0, o_dmem_req}, 32'd0);
        check({name, "_req_cycles"}, 32'(n_req), 32'(exp_req));
        check({name, "_stall_cycles"}, 32'(n_stall), 32'(exp_stall));
        next_cycle();
    endtask

    task automatic run_load(input string name, input logic [31:0] addr, input logic [2:0] f3,
                            input logic [4:0] rd, input logic [31:0] rdata, input int gnt_dly,
                            input int rsp_dly, input logic [31:0] exp_val, input int exp_req,
                            input int exp_stall);
        int n_req   = 0;
        int n_stall = 0;
        push_exp(exp_val, rd);
        set_op(addr, 32'h0, f3, rd, 1'b1, 1'b0, 1'b1, 2'b01, 32'h0);
        for (int c = 0; c <= gnt_dly + rsp_dly; c++) begin
            i_dmem_gnt    = (c == gnt_dly);
            i_dmem_rvalid = (c == gnt_dly + rsp_dly);
            i_dmem_rdata  = (c == gnt_dly + rsp_dly) ? rdata : 32'h0;
            @(negedge clk);
            if (o_dmem_req) n_req++;
            if (o_stall) n_stall++;
            if (c == 0) check({name, "_wstrb"}, {28'b0, o_dmem_wstrb}, 32'd0);
            next_cycle();
        end
        set_bubble();
        i_dmem_gnt    = 1'b0;
        i_dmem_rvalid = 1'b0;
        @(negedge clk);
        check({name, "_stall_after"}, {31'b0, o_stall}, 32'd0);
        check({name, "_req_cycles"}, 32'(n_req), 32'(exp_req));
        check({name, "_stall_cycles"}, 32'(n_stall), 32'(exp_stall));
        next_cycle();
    endtask

    task automatic run_timeout();
        int err_at = -1;
        set_op(32'h4000, 32'h0, 3'b010, 5'd4, 1'b1, 1'b0, 1'b1, 2'b01, 32'h0);
        i_dmem_gnt = 1'b1;
        for (int c = 0; c < 12 && err_at < 0; c++) begin
            @(negedge clk);
            if (o_bus_err) err_at = c;
            next_cycle();
            i_dmem_gnt = 1'b0;
        end
        check("timeout_cycle", 32'(err_at), 32'd4);
        set_bubble();
        @(negedge clk);
        check("timeout_stall", {31'b0, o_stall}, 32'd0);
        check("timeout_bubble", {31'b0, o_RegSrcW}, 32'd0);
        check("timeout_err_pulse", {31'b0, o_bus_err}, 32'd0);
        next_cycle();
        i_dmem_rvalid = 1'b1;
        i_dmem_rdata  = 32'hBAD0BAD0;
        next_cycle();
        i_dmem_rvalid = 1'b0;
        @(negedge clk);
        check("timeout_stray_rvalid", {31'b0, o_RegSrcW}, 32'd0);
        next_cycle();
    endtask

    task automatic run_reset_mid();
        set_op(32'h5000, 32'h0, 3'b010, 5'd6, 1'b1, 1'b0, 1'b1, 2'b01, 32'h0);
        i_dmem_gnt = 1'b1;
        @(negedge clk);
        check("rst_mid_req", {31'b0, o_dmem_req}, 32'd1);
        next_cycle();
        i_dmem_gnt = 1'b0;
        @(negedge clk);
        check("rst_mid_wait_stall", {31'b0, o_stall}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("rst_mid_req_drop", {31'b0, o_dmem_req}, 32'd0);
        check("rst_mid_stall_drop", {31'b0, o_stall}, 32'd0);
        next_cycle();
        set_bubble();
        rst = 1'b0;
        i_dmem_rvalid = 1'b1;
        i_dmem_rdata  = 32'h12345678;
        @(negedge clk);
        check("rst_mid_stall_after", {31'b0, o_stall}, 32'd0);
        next_cycle();
        i_dmem_rvalid = 1'b0;
        @(negedge clk);
        check("rst_mid_no_wb", {31'b0, o_RegSrcW}, 32'd0);
        next_cycle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach its end, expected completion");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        set_bubble();
        i_dmem_gnt = 1'b0; i_dmem_rvalid = 1'b0; i_dmem_rdata = 32'h0;
        fork
            monitor();
        join_none
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_req", {31'b0, o_dmem_req}, 32'd0);
        check("reset_stall", {31'b0, o_stall}, 32'd0);
        check("reset_regsrc", {31'b0, o_RegSrcW}, 32'd0);
        check("reset_result", o_ResultW, 32'd0);
        check("reset_rd", {27'b0, o_RdW}, 32'd0);
        next_cycle();
        rst = 1'b0;
        next_cycle();

        // ALU write-backs, back to back, covering each WB select.
        run_alu(32'h0000_1234, 5'd5,  1'b1, 2'b00, 32'h0000_0100, 32'h0000_1234);
        run_alu(32'hCAFE_F00D, 5'd1,  1'b1, 2'b10, 32'hFFFF_FFFC, 32'h0000_0000);
        run_alu(32'h0000_0055, 5'd31, 1'b1, 2'b11, 32'h0000_0010, 32'h0000_0055);
        run_alu(32'h0000_0777, 5'd2,  1'b1, 2'b10, 32'h0000_0080, 32'h0000_0084);
        run_alu(32'h0000_9999, 5'd3,  1'b0, 2'b00, 32'h0000_0000, 32'h0000_0000);
        set_bubble();
        next_cycle();

        run_store("sb",  32'h0000_1003, 32'hAABB_CCDD, 3'b000, 0, 32'hDDDD_DDDD, 4'b1000, 1, 0);
        run_store("sh",  32'h0000_1002, 32'h1234_ABCD, 3'b001, 1, 32'hABCD_ABCD, 4'b1100, 2, 2);
        run_store("sw",  32'h0000_100C, 32'h0102_0304, 3'b010, 0, 32'h0102_0304, 4'b1111, 1, 0);
        run_store("sb1", 32'h0000_1001, 32'h0000_005A, 3'b000, 0, 32'h5A5A_5A5A, 4'b0010, 1, 0);

        run_load("lb",   32'h0000_2002, 3'b000, 5'd7,  32'h0080_FF00, 0, 1, 32'hFFFF_FF80, 1, 2);
        run_load("lbu",  32'h0000_2002, 3'b100, 5'd8,  32'h0080_FF00, 0, 1, 32'h0000_0080, 1, 2);
        run_load("lw",   32'h0000_3000, 3'b010, 5'd9,  32'hDEAD_BEEF, 3, 2, 32'hDEAD_BEEF, 4, 6);
        run_load("lh",   32'h0000_2002, 3'b001, 5'd10, 32'h8001_1234, 0, 1, 32'hFFFF_8001, 1, 2);
        run_load("lhu",  32'h0000_2000, 3'b101, 5'd11, 32'h8001_1234, 1, 3, 32'h0000_1234, 2, 5);
        run_load("lb1",  32'h0000_2001, 3'b000, 5'd12, 32'h0000_7F00, 0, 1, 32'h0000_007F, 1, 2);

        // Misaligned halfword load and word store are dropped without a stall.
        set_op(32'h0000_0001, 32'h0, 3'b001, 5'd3, 1'b1, 1'b0, 1'b1, 2'b01, 32'h0);
        @(negedge clk);
        check("mis_lh_pulse", {31'b0, o_misaligned}, 32'd1);
        check("mis_lh_req", {31'b0, o_dmem_req}, 32'd0);
        check("mis_lh_stall", {31'b0, o_stall}, 32'd0);
        next_cycle();
        set_op(32'h0000_0002, 32'hFFFF_FFFF, 3'b010, 5'd0, 1'b0, 1'b1, 1'b0, 2'b00, 32'h0);
        @(negedge clk);
        check("mis_lh_bubble", {31'b0, o_RegSrcW}, 32'd0);
        check("mis_sw_pulse", {31'b0, o_misaligned}, 32'd1);
        check("mis_sw_req", {31'b0, o_dmem_req}, 32'd0);
        next_cycle();
        set_bubble();
        @(negedge clk);
        check("mis_pulse_end", {31'b0, o_misaligned}, 32'd0);
        next_cycle();

        run_timeout();
        run_reset_mid();

        repeat (3) next_cycle();
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
